// File: rtl/int_issue_queue.sv
// Age-ordered integer/branch reservation queue: dispatch, CDB wakeup, oldest-ready
// select through a single-cycle ALU, and issue with in-place compaction.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              flush_valid,
  input  logic              disp_valid,
  input  logic [2:0]        disp_opcode,
  input  logic [4:0]        disp_tag,
  input  logic              disp_rs_valid,
  input  logic [DATA_W-1:0] disp_rs_data,
  input  logic [4:0]        disp_rs_tag,
  input  logic              disp_rt_valid,
  input  logic [DATA_W-1:0] disp_rt_data,
  input  logic [4:0]        disp_rt_tag,
  output logic              disp_full,
  input  logic              cdb_valid,
  input  logic [4:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              int_ready,
  output logic [DATA_W-1:0] int_dout,
  output logic [4:0]        int_tag,
  output logic              int_branch,
  output logic              int_branch_taken,
  input  logic              int_issue
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLT = 3'd5, OP_BEQ = 3'd6, OP_BNE = 3'd7;

  function automatic logic [DATA_W-1:0] alu_result(input logic [2:0] op,
                                                   input logic signed [DATA_W-1:0] a,
                                                   input logic signed [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return DATA_W'(a < b);
      default: return '0;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] op,
                                        input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    case (op)
      OP_BEQ:  return a == b;
      OP_BNE:  return a != b;
      default: return 1'b0;
    endcase
  endfunction

  logic [DEPTH-1:0]  busy, n_busy;
  logic [CW-1:0]     count, n_count;
  logic [2:0]        opcode   [DEPTH], n_opcode   [DEPTH];
  logic [4:0]        tag      [DEPTH], n_tag      [DEPTH];
  logic              rs_valid [DEPTH], n_rs_valid [DEPTH], w_rs_valid [DEPTH];
  logic [DATA_W-1:0] rs_data  [DEPTH], n_rs_data  [DEPTH], w_rs_data  [DEPTH];
  logic [4:0]        rs_tag   [DEPTH], n_rs_tag   [DEPTH];
  logic              rt_valid [DEPTH], n_rt_valid [DEPTH], w_rt_valid [DEPTH];
  logic [DATA_W-1:0] rt_data  [DEPTH], n_rt_data  [DEPTH], w_rt_data  [DEPTH];
  logic [4:0]        rt_tag   [DEPTH], n_rt_tag   [DEPTH];

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          do_issue, do_disp;
  logic [IW-1:0] wr_idx;

  assign disp_full = (count == CW'(DEPTH));
  assign do_issue  = int_issue && sel_found;
  assign do_disp   = disp_valid && !disp_full;

  // Select: oldest busy entry with both operands present
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && busy[i] && rs_valid[i] && rt_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    int_ready        = sel_found;
    int_dout         = '0;
    int_tag          = '0;
    int_branch       = 1'b0;
    int_branch_taken = 1'b0;
    if (sel_found) begin
      int_dout         = alu_result(opcode[sel_idx], rs_data[sel_idx], rt_data[sel_idx]);
      int_tag          = tag[sel_idx];
      int_branch       = (opcode[sel_idx] == OP_BEQ) || (opcode[sel_idx] == OP_BNE);
      int_branch_taken = branch_taken(opcode[sel_idx], rs_data[sel_idx], rt_data[sel_idx]);
    end
  end

  // Wakeup: waiting operands capture a matching CDB broadcast
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_rs_valid[i] = rs_valid[i];
      w_rs_data[i]  = rs_data[i];
      w_rt_valid[i] = rt_valid[i];
      w_rt_data[i]  = rt_data[i];
      if (!rs_valid[i] && cdb_valid && rs_tag[i] == cdb_tag) begin
        w_rs_valid[i] = 1'b1;
        w_rs_data[i]  = cdb_data;
      end
      if (!rt_valid[i] && cdb_valid && rt_tag[i] == cdb_tag) begin
        w_rt_valid[i] = 1'b1;
        w_rt_data[i]  = cdb_data;
      end
    end
  end

  // Compaction over the issued slot, then dispatch lands after the youngest entry
  always_comb begin
    n_busy  = busy;
    n_count = count;
    wr_idx  = count[IW-1:0] - IW'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      int j;
      j = (do_issue && i >= int'(sel_idx)) ? i + 1 : i;
      n_opcode[i]   = opcode[i];
      n_tag[i]      = tag[i];
      n_rs_valid[i] = w_rs_valid[i];
      n_rs_data[i]  = w_rs_data[i];
      n_rs_tag[i]   = rs_tag[i];
      n_rt_valid[i] = w_rt_valid[i];
      n_rt_data[i]  = w_rt_data[i];
      n_rt_tag[i]   = rt_tag[i];
      if (j < DEPTH) begin
        n_busy[i]     = busy[j];
        n_opcode[i]   = opcode[j];
        n_tag[i]      = tag[j];
        n_rs_valid[i] = w_rs_valid[j];
        n_rs_data[i]  = w_rs_data[j];
        n_rs_tag[i]   = rs_tag[j];
        n_rt_valid[i] = w_rt_valid[j];
        n_rt_data[i]  = w_rt_data[j];
        n_rt_tag[i]   = rt_tag[j];
      end else begin
        n_busy[i] = 1'b0;
      end
    end
    if (do_disp) begin
      n_busy[wr_idx]     = 1'b1;
      n_opcode[wr_idx]   = disp_opcode;
      n_tag[wr_idx]      = disp_tag;
      n_rs_valid[wr_idx] = disp_rs_valid || (cdb_valid && disp_rs_tag == cdb_tag);
      n_rs_data[wr_idx]  = disp_rs_valid ? disp_rs_data : cdb_data;
      n_rs_tag[wr_idx]   = disp_rs_tag;
      n_rt_valid[wr_idx] = disp_rt_valid || (cdb_valid && disp_rt_tag == cdb_tag);
      n_rt_data[wr_idx]  = disp_rt_valid ? disp_rt_data : cdb_data;
      n_rt_tag[wr_idx]   = disp_rt_tag;
    end
    if (do_disp && !do_issue)
      n_count = count + CW'(1);
    else if (!do_disp && do_issue)
      n_count = count - CW'(1);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      busy  <= '0;
      count <= '0;
    end else if (flush_valid) begin
      busy  <= '0;
      count <= '0;
    end else begin
      busy  <= n_busy;
      count <= n_count;
    end
  end

  // Payload is only observed through busy, so it carries no reset
  always_ff @(posedge clock) begin
    opcode   <= n_opcode;
    tag      <= n_tag;
    rs_valid <= n_rs_valid;
    rs_data  <= n_rs_data;
    rs_tag   <= n_rs_tag;
    rt_valid <= n_rt_valid;
    rt_data  <= n_rt_data;
    rt_tag   <= n_rt_tag;
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: ALU vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_int_issue_queue;

  logic        clock = 1'b0;
  logic        nreset;
  logic        flush_valid, disp_valid;
  logic [2:0]  disp_opcode;
  logic [4:0]  disp_tag, disp_rs_tag, disp_rt_tag;
  logic        disp_rs_valid, disp_rt_valid;
  logic [31:0] disp_rs_data, disp_rt_data;
  logic        disp_full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        int_ready, int_branch, int_branch_taken, int_issue;
  logic [31:0] int_dout;
  logic [4:0]  int_tag;

  int n_cmp = 0;
  int n_bad = 0;

  int_issue_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clock(clock), .nreset(nreset), .flush_valid(flush_valid),
    .disp_valid(disp_valid), .disp_opcode(disp_opcode), .disp_tag(disp_tag),
    .disp_rs_valid(disp_rs_valid), .disp_rs_data(disp_rs_data), .disp_rs_tag(disp_rs_tag),
    .disp_rt_valid(disp_rt_valid), .disp_rt_data(disp_rt_data), .disp_rt_tag(disp_rt_tag),
    .disp_full(disp_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .int_ready(int_ready), .int_dout(int_dout), .int_tag(int_tag),
    .int_branch(int_branch), .int_branch_taken(int_branch_taken), .int_issue(int_issue)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, dout;
    logic        br, tk;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  tag;
    logic        rsv;
    logic [31:0] rsd;
    logic [4:0]  rst;
    logic        rtv;
    logic [31:0] rtd;
    logic [4:0]  rtt;
  } ent_t;

  vec_t vt[12];
  ent_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; cdb_valid = 0; int_issue = 0; flush_valid = 0;
  endtask

  task automatic set_disp(input logic [2:0] op, input logic [4:0] tg,
                          input logic rsv, input logic [31:0] rsd, input logic [4:0] rst,
                          input logic rtv, input logic [31:0] rtd, input logic [4:0] rtt);
    disp_valid = 1; disp_opcode = op; disp_tag = tg;
    disp_rs_valid = rsv; disp_rs_data = rsd; disp_rs_tag = rst;
    disp_rt_valid = rtv; disp_rt_data = rtd; disp_rt_tag = rtt;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, ".ready"}, 32'(int_ready), 0);
    check({name, ".dout"}, int_dout, 0);
    check({name, ".tag"}, 32'(int_tag), 0);
    check({name, ".branch"}, 32'(int_branch), 0);
    check({name, ".taken"}, 32'(int_branch_taken), 0);
  endtask

  // Reference ALU straight from the opcode table
  function automatic logic [31:0] m_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    vt[0]  = '{3'd0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
    vt[1]  = '{3'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = '{3'd2, 32'hF0F0FFFF, 32'h0FF00F0F, 32'h00F00F0F, 1'b0, 1'b0};
    vt[3]  = '{3'd3, 32'h0000F000, 32'h00000F0F, 32'h0000FF0F, 1'b0, 1'b0};
    vt[4]  = '{3'd4, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1'b0};
    vt[5]  = '{3'd5, 32'h80000000, 32'd1,        32'd1,        1'b0, 1'b0};
    vt[6]  = '{3'd5, 32'd1,        32'h80000000, 32'd0,        1'b0, 1'b0};
    vt[7]  = '{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b1};
    vt[8]  = '{3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
    vt[9]  = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0};
    vt[10] = '{3'd6, 32'd1,        32'd2,        32'd0,        1'b1, 1'b0};
    vt[11] = '{3'd7, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1};

    nreset = 0;
    idle();
    set_disp(3'd0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 0; cdb_tag = 0; cdb_data = 0;
    @(negedge clock);
    check_idle_outputs("reset");
    check("reset.full", 32'(disp_full), 0);
    @(negedge clock);
    nreset = 1;
    tick();

    // ALU vectors: one fully-valid dispatch into an empty queue each
    for (int i = 0; i < 12; i++) begin
      set_disp(vt[i].op, 5'(i + 1), 1, vt[i].rs, 0, 1, vt[i].rt, 0);
      tick();
      idle();
      @(negedge clock);
      check($sformatf("vec%0d.ready", i), 32'(int_ready), 1);
      check($sformatf("vec%0d.dout", i), int_dout, vt[i].dout);
      check($sformatf("vec%0d.tag", i), 32'(int_tag), 32'(i + 1));
      check($sformatf("vec%0d.branch", i), 32'(int_branch), 32'(vt[i].br));
      check($sformatf("vec%0d.taken", i), 32'(int_branch_taken), 32'(vt[i].tk));
      int_issue = 1;
      tick();
      int_issue = 0;
      @(negedge clock);
      check($sformatf("vec%0d.drained", i), 32'(int_ready), 0);
    end
    tick();

    // Wakeup from the CDB after several idle cycles
    set_disp(3'd1, 4, 0, 0, 9, 1, 2, 0);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("wake.waiting", 32'(int_ready), 0);
      tick();
    end
    cdb_valid = 1; cdb_tag = 9; cdb_data = 10;
    tick();
    cdb_valid = 0;
    @(negedge clock);
    check("wake.ready", 32'(int_ready), 1);
    check("wake.dout", int_dout, 8);
    check("wake.tag", 32'(int_tag), 4);
    int_issue = 1;
    tick();
    int_issue = 0;

    // Dispatch-time bypass of a broadcast matching the incoming tag
    set_disp(3'd0, 7, 0, 0, 12, 1, 1, 0);
    cdb_valid = 1; cdb_tag = 12; cdb_data = 100;
    tick();
    idle();
    @(negedge clock);
    check("bypass.ready", 32'(int_ready), 1);
    check("bypass.dout", int_dout, 101);
    int_issue = 1;
    tick();
    int_issue = 0;

    // Age order, full queue, refused dispatch while full
    for (int k = 1; k <= 4; k++) begin
      set_disp(3'd0, 5'(k), 1, 32'(k), 0, 1, 0, 0);
      tick();
    end
    idle();
    @(negedge clock);
    check("age.full", 32'(disp_full), 1);
    set_disp(3'd0, 5, 1, 5, 0, 1, 0, 0);
    tick();
    idle();
    @(negedge clock);
    check("age.still_full", 32'(disp_full), 1);
    check("age.tag1", 32'(int_tag), 1);
    int_issue = 1;
    set_disp(3'd0, 6, 1, 6, 0, 1, 0, 0);
    tick();
    disp_valid = 0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clock);
      check($sformatf("age.tag%0d", k), 32'(int_tag), 32'(k));
      check($sformatf("age.dout%0d", k), int_dout, 32'(k));
      check($sformatf("age.notfull%0d", k), 32'(disp_full), 0);
      tick();
    end
    int_issue = 0;
    @(negedge clock);
    check("age.empty", 32'(int_ready), 0);
    check("age.empty_full", 32'(disp_full), 0);

    // Younger ready entry overtakes an older waiting one
    set_disp(3'd0, 10, 0, 0, 20, 1, 1, 0);
    tick();
    set_disp(3'd0, 11, 1, 3, 0, 1, 4, 0);
    tick();
    idle();
    @(negedge clock);
    check("ooo.tag_young", 32'(int_tag), 11);
    check("ooo.dout_young", int_dout, 7);
    int_issue = 1;
    tick();
    int_issue = 0;
    @(negedge clock);
    check("ooo.none_ready", 32'(int_ready), 0);
    cdb_valid = 1; cdb_tag = 20; cdb_data = 5;
    tick();
    cdb_valid = 0;
    @(negedge clock);
    check("ooo.tag_old", 32'(int_tag), 10);
    check("ooo.dout_old", int_dout, 6);
    int_issue = 1;
    tick();
    int_issue = 0;

    // Flush wins over a simultaneous dispatch
    for (int k = 1; k <= 3; k++) begin
      set_disp(3'd0, 5'(k), 1, 1, 0, 1, 1, 0);
      tick();
    end
    flush_valid = 1;
    set_disp(3'd0, 9, 1, 1, 0, 1, 1, 0);
    tick();
    idle();
    @(negedge clock);
    check_idle_outputs("flush");
    check("flush.full", 32'(disp_full), 0);
    for (int k = 1; k <= 3; k++) begin
      set_disp(3'd0, 5'(k), 1, 1, 0, 1, 1, 0);
      tick();
    end
    idle();
    @(negedge clock);
    check("flush.count3", 32'(disp_full), 0);

    // Asynchronous reset mid-stream, observed between clock edges
    check("areset.pre", 32'(int_ready), 1);
    #2 nreset = 0;
    #1;
    check_idle_outputs("areset");
    check("areset.full", 32'(disp_full), 0);
    #1 nreset = 1;
    tick();

    // Randomized traffic against the reference queue
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int sel;
      logic full;
      disp_valid    = ($urandom_range(0, 9) < 6);
      disp_opcode   = 3'($urandom_range(0, 7));
      disp_tag      = 5'($urandom_range(0, 31));
      disp_rs_valid = $urandom_range(0, 1) == 1;
      disp_rt_valid = $urandom_range(0, 1) == 1;
      disp_rs_data  = $urandom;
      disp_rt_data  = ($urandom_range(0, 3) == 0) ? disp_rs_data : $urandom;
      disp_rs_tag   = 5'($urandom_range(0, 7));
      disp_rt_tag   = 5'($urandom_range(0, 7));
      cdb_valid     = ($urandom_range(0, 9) < 4);
      cdb_tag       = 5'($urandom_range(0, 7));
      cdb_data      = $urandom;
      int_issue     = ($urandom_range(0, 9) < 7);
      flush_valid   = ($urandom_range(0, 49) == 0);
      @(negedge clock);
      sel = -1;
      foreach (q[i]) if (sel < 0 && q[i].rsv && q[i].rtv) sel = i;
      full = (q.size() == 4);
      check("rnd.full", 32'(disp_full), 32'(full));
      check("rnd.ready", 32'(int_ready), 32'(sel >= 0));
      if (sel >= 0) begin
        logic is_br;
        is_br = (q[sel].op == 3'd6) || (q[sel].op == 3'd7);
        check("rnd.dout", int_dout, m_res(q[sel].op, q[sel].rsd, q[sel].rtd));
        check("rnd.tag", 32'(int_tag), 32'(q[sel].tag));
        check("rnd.branch", 32'(int_branch), 32'(is_br));
        check("rnd.taken", 32'(int_branch_taken),
              32'(is_br && ((q[sel].op == 3'd6) == (q[sel].rsd == q[sel].rtd))));
      end else begin
        check("rnd.idle_dout", int_dout, 0);
      end
      if (flush_valid) begin
        q.delete();
      end else begin
        ent_t e;
        foreach (q[i]) begin
          if (cdb_valid && !q[i].rsv && q[i].rst == cdb_tag) begin q[i].rsv = 1; q[i].rsd = cdb_data; end
          if (cdb_valid && !q[i].rtv && q[i].rtt == cdb_tag) begin q[i].rtv = 1; q[i].rtd = cdb_data; end
        end
        if (int_issue && sel >= 0) q.delete(sel);
        if (disp_valid && !full) begin
          e = '{disp_opcode, disp_tag, disp_rs_valid, disp_rs_data, disp_rs_tag,
                disp_rt_valid, disp_rt_data, disp_rt_tag};
          if (!e.rsv && cdb_valid && e.rst == cdb_tag) begin e.rsv = 1; e.rsd = cdb_data; end
          if (!e.rtv && cdb_valid && e.rtt == cdb_tag) begin e.rtv = 1; e.rtd = cdb_data; end
          q.push_back(e);
        end
      end
      tick();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
